// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard control for a 5-stage pipeline: load-use stall, branch
//            mispredict flush/redirect, bounded data-memory freeze with a
//            sticky timeout flag, and stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        mem_access,
    input  logic        dmem_ready,
    input  logic        mem_mispredict,
    input  logic [31:0] mem_redirect_pc,
    input  logic        cnt_clr,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        pipe_freeze,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        bus_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_bus_err;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    logic        w_load_use;
    logic        w_timeout;
    logic        w_freeze;
    logic        w_bus_err_set;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Once the access has been frozen TIMEOUT cycles the pipeline is let go.
    assign w_timeout     = (r_state == S_WAIT) && (r_wait_cnt == c_TIMEOUT);
    assign w_freeze      = mem_access && !dmem_ready && !w_timeout;
    assign w_bus_err_set = (r_state == S_WAIT) && !w_freeze &&
                           (r_wait_cnt == c_TIMEOUT) && !dmem_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        pc_redirect    = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_freeze) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                if (w_freeze) begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase

        // Freeze outranks mispredict, which outranks load-use.
        if (w_freeze) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (mem_mispredict) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_redirect  = 1'b1;
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_bus_err_set) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else if (cnt_clr) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (pc_redirect) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign pipe_freeze  = w_freeze;
    assign redirect_pc  = mem_redirect_pc;
    assign bus_err      = r_bus_err;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, range 1..255: maximum freeze cycles allowed for one data-memory access.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- mem_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- mem_mispredict  in  1  branch or jump resolved in MEM was mispredicted
- mem_redirect_pc  in  32  correct PC for that branch or jump
- cnt_clr  in  1  synchronous clear of the performance counters
- pc_stall, if_id_stall  out  1 each  hold the PC and the IF/ID register
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  bubble the named register
- pc_redirect  out  1  load redirect_pc into the PC
- redirect_pc  out  32  redirect target
- bus_err  out  1  sticky access-timeout flag
- stall_cycles, flush_count  out  32 each  performance counters

Function
REQ-003 SHALL define load_use = ex_mem_read AND ex_rd!=0 AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).
REQ-004 SHALL implement a 2-state FSM with states RUN and WAIT, plus an 8-bit wait_cnt.
REQ-005 SHALL assert pipe_freeze = mem_access AND NOT dmem_ready AND NOT (state==WAIT AND wait_cnt==TIMEOUT).
REQ-006 FSM transitions SHALL be:
- RUN to WAIT when pipe_freeze=1, with wait_cnt set to 1.
- WAIT to WAIT while pipe_freeze=1, with wait_cnt incremented.
- WAIT to RUN when pipe_freeze=0, with wait_cnt cleared to 0.
REQ-007 An access SHALL therefore be frozen for at most TIMEOUT cycles; the pipeline advances in the following cycle.
REQ-008 When WAIT is left with wait_cnt==TIMEOUT and dmem_ready=0, bus_err SHALL set at that edge and stay set until reset.
REQ-009 While pipe_freeze=1, pc_stall and if_id_stall SHALL be 1, and all flush outputs and pc_redirect SHALL be 0; freeze has top priority.
REQ-010 When pipe_freeze=0 and mem_mispredict=1:
- if_id_flush, id_ex_flush, ex_mem_flush and pc_redirect SHALL be 1.
- pc_stall and if_id_stall SHALL be 0.
- load_use SHALL be ignored.
REQ-011 When pipe_freeze=0, mem_mispredict=0 and load_use=1, pc_stall, if_id_stall and id_ex_flush SHALL be 1 for exactly that cycle; no state is kept.
REQ-012 redirect_pc SHALL equal mem_redirect_pc combinationally at all times.
REQ-013 All stall, flush and redirect outputs SHALL be combinational, with zero-cycle latency from the inputs.
REQ-014 stall_cycles SHALL increment by 1 on each edge where pc_stall=1.
REQ-015 flush_count SHALL increment by 1 on each edge where pc_redirect=1.
REQ-016 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 cnt_clr=1 SHALL zero both counters at the next edge and SHALL override any increment in that cycle.

Reset
REQ-018 rst=1 SHALL immediately force state=RUN, wait_cnt=0, bus_err=0, stall_cycles=0 and flush_count=0, including mid-WAIT.
REQ-019 After reset release, the combinational outputs SHALL follow the inputs starting with the first cycle.

Verification
REQ-020 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle; stall_cycles increases by 1.
REQ-021 Same as REQ-020 but ex_rd=0 -> no stall and no flush.
REQ-022 Mispredict together with load_use, mem_redirect_pc=0x00000100 -> flushes=1, pc_redirect=1, redirect_pc=0x00000100, pc_stall=0; flush_count increases by 1.
REQ-023 TIMEOUT=4, mem_access=1, dmem_ready held 0 -> pipe_freeze=1 for 4 cycles, then 0; bus_err=1 from the next edge; FSM returns to RUN.
REQ-024 Three cycles into a WAIT: (a) dmem_ready=1 -> freeze drops in the same cycle and bus_err stays 0; (b) rst pulse -> state=RUN and counters=0.
REQ-025 stall_cycles preloaded to 0xFFFFFFFF by stalling -> wraps to 0; cnt_clr asserted in the same cycle as a stall -> counter=0.
